// File: rtl/stream_monitor.sv
// Passive valid/ready protocol monitor for CH_NB independent streams.
// It flags drops, payload instability, framing and stall-timeout errors, and counts completed frames.
module stream_monitor #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int CH_NB      = 4,
  parameter int DWIDTH     = 64,
  parameter int CNT_WIDTH  = 16,
  parameter logic [CFG_AWIDTH-1:0] CFG_MON_LEN   = 5'd24,
  parameter logic [CFG_AWIDTH-1:0] CFG_MON_STALL = 5'd25,
  parameter logic [CFG_AWIDTH-1:0] CFG_MON_CLR   = 5'd26
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CFG_DWIDTH-1:0]      cfg_data,
  input  logic [CFG_AWIDTH-1:0]      cfg_addr,
  input  logic                       cfg_valid,
  input  logic [CH_NB*DWIDTH-1:0]    mon_data,
  input  logic [CH_NB-1:0]           mon_last,
  input  logic [CH_NB-1:0]           mon_val,
  input  logic [CH_NB-1:0]           mon_rdy,
  output logic [CH_NB*4-1:0]         err_flags,
  output logic                       err_any,
  output logic [CH_NB*CNT_WIDTH-1:0] frame_cnt
);

  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] stall_lim_q;
  logic                 err_any_q;
  logic                 clr;
  logic                 unused_cfg;

  assign clr        = cfg_valid && (cfg_addr == CFG_MON_CLR);
  assign unused_cfg = ^cfg_data[CFG_DWIDTH-1:CNT_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q       <= '0;
      stall_lim_q <= '0;
      err_any_q   <= 1'b0;
    end else begin
      if (cfg_valid && cfg_addr == CFG_MON_LEN)   len_q       <= cfg_data[CNT_WIDTH-1:0];
      if (cfg_valid && cfg_addr == CFG_MON_STALL) stall_lim_q <= cfg_data[CNT_WIDTH-1:0];
      err_any_q <= |err_flags;
    end
  end

  assign err_any = err_any_q;

  for (genvar g = 0; g < CH_NB; g++) begin : g_ch
    logic [DWIDTH-1:0]    data, data_prev_q;
    logic                 last, last_prev_q, stall_prev_q;
    logic                 beat, stall, drop, stab, fr_err, to_err, len_hit;
    logic [3:0]           viol, flags_q;
    logic [CNT_WIDTH-1:0] bcnt_q, scnt_q, frame_q, bcnt_sat, scnt_sat;
    logic [CNT_WIDTH:0]   bcnt_p1, scnt_p1;

    assign data  = mon_data[g*DWIDTH +: DWIDTH];
    assign last  = mon_last[g];
    assign beat  = mon_val[g] & mon_rdy[g];
    assign stall = mon_val[g] & ~mon_rdy[g];

    // Compare one bit wider so a saturated counter never aliases to a small limit.
    assign bcnt_p1  = {1'b0, bcnt_q} + (CNT_WIDTH+1)'(1);
    assign scnt_p1  = {1'b0, scnt_q} + (CNT_WIDTH+1)'(1);
    assign bcnt_sat = (&bcnt_q) ? bcnt_q : bcnt_p1[CNT_WIDTH-1:0];
    assign scnt_sat = (&scnt_q) ? scnt_q : scnt_p1[CNT_WIDTH-1:0];
    assign len_hit  = (bcnt_p1 == {1'b0, len_q});

    assign drop   = stall_prev_q & ~mon_val[g];
    assign stab   = stall_prev_q & mon_val[g] & ((data != data_prev_q) | (last != last_prev_q));
    assign fr_err = (len_q != '0) & beat & (last ? ~len_hit : len_hit);
    assign to_err = stall & (stall_lim_q != '0) & (scnt_p1 == {1'b0, stall_lim_q});
    assign viol   = {to_err, fr_err, stab, drop};

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stall_prev_q <= 1'b0;
        data_prev_q  <= '0;
        last_prev_q  <= 1'b0;
        flags_q      <= '0;
        bcnt_q       <= '0;
        scnt_q       <= '0;
        frame_q      <= '0;
      end else begin
        stall_prev_q <= stall;
        data_prev_q  <= data;
        last_prev_q  <= last;
        flags_q      <= clr ? viol : (flags_q | viol);

        // Activity in the clear cycle survives the clear as a count of one.
        if (clr)       bcnt_q <= (beat & ~last) ? CNT_WIDTH'(1) : '0;
        else if (beat) bcnt_q <= last ? '0 : bcnt_sat;

        if (clr)        scnt_q <= stall ? CNT_WIDTH'(1) : '0;
        else if (stall) scnt_q <= scnt_sat;
        else            scnt_q <= '0;

        if (clr)                               frame_q <= (beat & last) ? CNT_WIDTH'(1) : '0;
        else if (beat && last && !(&frame_q))  frame_q <= frame_q + CNT_WIDTH'(1);
      end
    end

    assign err_flags[g*4 +: 4]                = flags_q;
    assign frame_cnt[g*CNT_WIDTH +: CNT_WIDTH] = frame_q;
  end

endmodule

// File: tb/tb_stream_monitor.sv
// Scoreboard bench for stream_monitor: a per-channel behavioural model predicts the outputs
// after every clock; a separate monitor pops and compares them on the falling edge.
module tb_stream_monitor;

  localparam int CH = 4;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam int CMAX = 65535;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       cfg_data = '0;
  logic [4:0]        cfg_addr = '0;
  logic              cfg_valid = 1'b0;
  logic [CH*DW-1:0]  mon_data = '0;
  logic [CH-1:0]     mon_last = '0;
  logic [CH-1:0]     mon_val = '0;
  logic [CH-1:0]     mon_rdy = '0;
  logic [CH*4-1:0]   err_flags;
  logic              err_any;
  logic [CH*CW-1:0]  frame_cnt;

  stream_monitor dut (
    .clk(clk), .rst(rst),
    .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .mon_data(mon_data), .mon_last(mon_last), .mon_val(mon_val), .mon_rdy(mon_rdy),
    .err_flags(err_flags), .err_any(err_any), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH*4-1:0]  flags;
    logic [CH*CW-1:0] frames;
    logic             any;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model state, in plain integers.
  int          m_len, m_slim;
  int          m_beats[CH], m_stalls[CH], m_frames[CH];
  bit [3:0]    m_flags[CH];
  bit          m_prev_stall[CH];
  logic [63:0] m_prev_data[CH];
  logic        m_prev_last[CH];
  bit          m_any;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic model_reset();
    m_len = 0; m_slim = 0; m_any = 0;
    for (int c = 0; c < CH; c++) begin
      m_beats[c] = 0; m_stalls[c] = 0; m_frames[c] = 0; m_flags[c] = 0;
      m_prev_stall[c] = 0; m_prev_data[c] = '0; m_prev_last[c] = 0;
    end
  endtask

  task automatic model_step();
    bit clr, v, r, l, beat, st;
    bit [3:0] viol;
    logic [63:0] d;
    clr = cfg_valid && cfg_addr == 5'd26;
    m_any = 0;
    for (int c = 0; c < CH; c++) if (m_flags[c] != 0) m_any = 1;
    for (int c = 0; c < CH; c++) begin
      v = mon_val[c]; r = mon_rdy[c]; l = mon_last[c]; d = mon_data[c*DW +: DW];
      beat = v && r; st = v && !r;
      viol = 0;
      if (m_prev_stall[c] && !v) viol[0] = 1;
      if (m_prev_stall[c] && v && (d !== m_prev_data[c] || l !== m_prev_last[c])) viol[1] = 1;
      if (beat && m_len != 0) begin
        if (l && m_beats[c] + 1 != m_len) viol[2] = 1;
        if (!l && m_beats[c] + 1 == m_len) viol[2] = 1;
      end
      if (st && m_slim != 0 && m_stalls[c] + 1 == m_slim) viol[3] = 1;
      m_flags[c] = clr ? viol : (m_flags[c] | viol);
      if (clr) begin m_beats[c] = 0; m_stalls[c] = 0; m_frames[c] = 0; end
      if (beat) m_beats[c] = l ? 0 : sat_inc(m_beats[c]);
      m_stalls[c] = st ? sat_inc(m_stalls[c]) : 0;
      if (beat && l) m_frames[c] = sat_inc(m_frames[c]);
      m_prev_stall[c] = st; m_prev_data[c] = d; m_prev_last[c] = l;
    end
    if (cfg_valid && cfg_addr == 5'd24) m_len  = int'(cfg_data[15:0]);
    if (cfg_valid && cfg_addr == 5'd25) m_slim = int'(cfg_data[15:0]);
  endtask

  // One clock: model the cycle with the current inputs, then queue the post-edge expectation.
  task automatic tick();
    exp_t e;
    if (!rst) model_reset();
    else model_step();
    @(posedge clk);
    for (int c = 0; c < CH; c++) begin
      e.flags[c*4 +: 4]   = m_flags[c];
      e.frames[c*CW +: CW] = CW'(m_frames[c]);
    end
    e.any = m_any;
    sb.push_back(e);
    #1;
  endtask

  task automatic set_ch(input int c, input logic v, input logic r, input logic l, input logic [63:0] d);
    mon_val[c] = v; mon_rdy[c] = r; mon_last[c] = l; mon_data[c*DW +: DW] = d;
  endtask

  task automatic idle_all();
    mon_val = '0; mon_rdy = '0; mon_last = '0; cfg_valid = 1'b0;
  endtask

  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("err_flags", 64'(err_flags), 64'(e.flags));
        chk("frame_cnt", 64'(frame_cnt), 64'(e.frames));
        chk("err_any", 64'(err_any), 64'(e.any));
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    model_reset();
    // Reset held while streams toggle.
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < CH; c++)
        set_ch(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 64'($urandom));
      tick();
    end
    @(negedge clk);
    chk("reset_flags", 64'(err_flags), 64'd0);
    chk("reset_frames", 64'(frame_cnt), 64'd0);
    idle_all();
    rst = 1'b1;
    tick();
    set_ch(0, 1, 0, 0, 64'h5); tick();
    set_ch(0, 0, 0, 0, 64'h5); tick();
    @(negedge clk);
    chk("drop_flag", 64'(err_flags[0]), 64'd1);
    idle_all(); tick();
    @(negedge clk);
    chk("drop_err_any", 64'(err_any), 64'd1);
    cfg_wr(5'd26, 0);

    // Stability.
    set_ch(1, 1, 0, 0, 64'hAA); tick();
    set_ch(1, 1, 1, 0, 64'hAB); tick();
    @(negedge clk);
    chk("stab_ch1_flags", 64'(err_flags[7:4]), 64'b0010);
    idle_all();
    cfg_wr(5'd26, 0);

    // Framing with LEN = 4.
    cfg_wr(5'd24, 4);
    for (int b = 0; b < 4; b++) begin set_ch(2, 1, 1, b == 3, 64'(b)); tick(); end
    idle_all(); @(negedge clk);
    chk("frame_ok_cnt", 64'(frame_cnt[47:32]), 64'd1);
    chk("frame_ok_flags", 64'(err_flags[11:8]), 64'd0);
    for (int b = 0; b < 3; b++) begin set_ch(2, 1, 1, b == 2, 64'(b)); tick(); end
    idle_all(); @(negedge clk);
    chk("frame_short_flag", 64'(err_flags[10]), 64'd1);
    chk("frame_short_cnt", 64'(frame_cnt[47:32]), 64'd2);
    for (int b = 0; b < 5; b++) begin set_ch(2, 1, 1, 0, 64'(b)); tick(); end
    idle_all(); @(negedge clk);
    chk("frame_long_flag", 64'(err_flags[10]), 64'd1);
    cfg_wr(5'd24, 0);
    cfg_wr(5'd26, 0);

    // Timeout with STALL = 8, then disabled over a long stall.
    cfg_wr(5'd25, 8);
    for (int i = 0; i < 7; i++) begin set_ch(3, 1, 0, 0, 64'h7); tick(); end
    @(negedge clk);
    chk("timeout_early", 64'(err_flags[15]), 64'd0);
    tick();
    @(negedge clk);
    chk("timeout_at_limit", 64'(err_flags[15]), 64'd1);
    cfg_wr(5'd25, 0);
    cfg_wr(5'd26, 0);
    for (int i = 0; i < 1000; i++) tick();
    @(negedge clk);
    chk("timeout_disabled", 64'(err_flags[15]), 64'd0);
    set_ch(3, 1, 1, 1, 64'h7); tick();
    idle_all();

    // Clear in the same cycle as a drop.
    set_ch(0, 1, 0, 0, 64'h1); tick();
    set_ch(0, 0, 0, 0, 64'h1);
    cfg_valid = 1'b1; cfg_addr = 5'd26; cfg_data = 0;
    tick();
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("clr_vs_drop_flags", 64'(err_flags), 64'h0001);
    chk("clr_vs_drop_frames", 64'(frame_cnt), 64'd0);

    // All channels streaming legal 2-beat frames.
    idle_all();
    cfg_wr(5'd24, 2);
    cfg_wr(5'd26, 0);
    for (int i = 0; i < 100; i++) begin
      for (int c = 0; c < CH; c++) set_ch(c, 1, 1, (i % 2) == 1, {$urandom, $urandom});
      tick();
    end
    idle_all(); tick(); tick();
    @(negedge clk);
    for (int c = 0; c < CH; c++) chk("concurrent_frames", 64'(frame_cnt[c*CW +: CW]), 64'd50);
    chk("concurrent_err_any", 64'(err_any), 64'd0);

    // Random traffic and config writes, with one mid-stream reset.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        @(negedge clk); #1;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
      end
      for (int c = 0; c < CH; c++)
        set_ch(c, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
               64'($urandom_range(0, 3)));
      if ($urandom_range(0, 19) == 0) begin
        cfg_valid = 1'b1;
        case ($urandom_range(0, 3))
          0: cfg_addr = 5'd24;
          1: cfg_addr = 5'd25;
          2: cfg_addr = 5'd26;
          default: cfg_addr = 5'd3;
        endcase
        cfg_data = 32'($urandom_range(0, 6));
      end else begin
        cfg_valid = 1'b0;
      end
      tick();
    end
    idle_all();
    tick();
    repeat (3) @(negedge clk);
    if (sb.size() != 0) chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_monitor.md
# stream_monitor

Synthesizable, parametrised handshake monitor for the coprocessor's valid/ready streams (image, kernel, result). It watches `CH_NB` independent channels passively and flags protocol violations: valid dropped before acceptance, payload changing while stalled, wrong frame length, and stall timeout. Flags are sticky and completed frames are counted, so the checks run both in silicon bring-up and under formal or simulation. It is programmed through the shared cfg bus and never drives the monitored handshakes.

## Interface
- `CFG_DWIDTH`, 32, cfg bus data width
- `CFG_AWIDTH`, 5, cfg bus address width
- `CH_NB`, 4, number of monitored channels
- `DWIDTH`, 64, payload width per channel
- `CNT_WIDTH`, 16, width of the beat, stall and frame counters
- `CFG_MON_LEN`, 5'd24, cfg address for the expected frame length in beats (`cfg_data[CNT_WIDTH-1:0]`); 0 disables the framing check
- `CFG_MON_STALL`, 5'd25, cfg address for the stall limit in cycles; 0 disables the timeout check
- `CFG_MON_CLR`, 5'd26, cfg address for clear; any write clears flags and counters
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `cfg_data`  in  CFG_DWIDTH  cfg write data
- `cfg_addr`  in  CFG_AWIDTH  cfg write address
- `cfg_valid`  in  1  cfg write strobe, one write per cycle
- `mon_data`  in  CH_NB*DWIDTH  channel payloads; channel i occupies `[i*DWIDTH +: DWIDTH]`
- `mon_last`  in  CH_NB  end-of-frame marker per channel
- `mon_val`  in  CH_NB  valid per channel
- `mon_rdy`  in  CH_NB  ready per channel
- `err_flags`  out  CH_NB*4  sticky flags per channel i at `[i*4 +: 4]`: bit0 drop, bit1 stability, bit2 framing, bit3 timeout
- `err_any`  out  1  registered OR of all `err_flags`
- `frame_cnt`  out  CH_NB*CNT_WIDTH  completed frames per channel, saturating

## Operation
- Beat: `val & rdy` on a channel. Stall: `val & ~rdy`.
- Per channel, register the previous cycle's stall state, data and last.
- Drop: the previous cycle was a stall and current `val` = 0. Sets bit0.
- Stability: the previous cycle was a stall, current `val` = 1, and data or last differs from the previous cycle's value. Sets bit1.
- Beat counter `bcnt`:
  - Applies only when LEN != 0.
  - On a beat with last: if `bcnt+1 != LEN`, set bit2; `bcnt` returns to 0.
  - On a beat without last: if `bcnt+1 == LEN`, set bit2 (missing last); `bcnt` increments.
  - `bcnt` saturates at all-ones.
- `bcnt` counts beats even when LEN = 0 and resets on every last beat.
- `frame_cnt` increments on every beat with last, irrespective of LEN or errors, and saturates at all-ones.
- Stall counter `scnt`: increments on each stall cycle and resets to 0 on a beat or when `val` = 0. When STALL != 0 and `scnt+1 == STALL` on a stall cycle, set bit3. `scnt` saturates.
- LEN/STALL writes take effect for comparisons from the next cycle; in-flight counters are not reset.
- Clear: zeroes `err_flags`, `bcnt`, `scnt`, `frame_cnt` for every channel. A violation or counter increment detected in the same cycle as the clear wins: its flag is set and its count is 1 after the clear.
- Writes to other cfg addresses are ignored.
- Channels are fully independent; no cross-channel checks.

## Timing
- All outputs are registered.
- A flag asserts on the clock edge at the end of the violating cycle and is visible the next cycle. `err_any` follows one cycle after the flag.
- Reset (async assert, sync release):
  - `err_flags`, `err_any`, `frame_cnt`, `bcnt`, `scnt`, and the previous-cycle registers are 0.
  - LEN = 0, STALL = 0; only the drop and stability checks are active.
- Reset asserted mid-frame discards all state. The first cycle after release has no "previous stall", so no drop or stability error can fire on it.
- Inputs are sampled only; the block adds no combinational path from inputs to any output.
- Throughput: every channel can beat every cycle with no monitor-induced limit.

## Test plan
- Reset: hold `rst` = 0 while toggling the streams -> all outputs 0; release, then stall ch0 for 1 cycle and drop `val` -> `err_flags[0]` = 1 next cycle, `err_any` = 1 one cycle later.
- Stability: ch1 stalls with data 0xAA, next cycle data 0xAB with `val` = 1 -> `err_flags[5]` = 1, and no other ch1 flag.
- Framing: LEN = 4. Ch2 sends 4 beats with last on the 4th -> `frame_cnt[2]` = 1, no error. Then 3 beats with last on the 3rd -> `err_flags[10]` = 1, `frame_cnt[2]` = 2. Then 5 beats with no last at beat 4 -> bit10 already set, stays set.
- Timeout: STALL = 8, ch3 held in stall -> `err_flags[15]` sets at the end of the 8th stall cycle. With STALL = 0, a 1000-cycle stall -> no flag.
- Clear vs violation: write `CFG_MON_CLR` in the same cycle ch0 drops after a stall -> all flags 0 except `err_flags[0]` = 1; `frame_cnt` = 0.
- Concurrency: all 4 channels beat every cycle with legal 2-beat frames for 100 cycles, LEN = 2 -> every `frame_cnt` = 50, `err_any` = 0.
